// File: rtl/mux_scanner_pkg.sv
// Shared types and constants for the multiplexed channel scanner.
package mux_scanner_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 4;
  localparam int DWELL_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scanner_if.sv
// Scan request / channel bus between a scanner and whoever drives it.
interface mux_scanner_if;

  logic                                 start;
  logic [mux_scanner_pkg::NUM_CH-1:0]   a;
  logic [mux_scanner_pkg::SEL_W-1:0]    sel;
  logic                                 o;
  logic [mux_scanner_pkg::NUM_CH-1:0]   data;
  logic                                 busy;
  logic                                 done;

  modport master (
    output start, a,
    input  sel, o, data, busy, done
  );

  modport slave (
    input  start, a,
    output sel, o, data, busy, done
  );

endinterface

// File: rtl/mux4to1.sv
// Plain 4:1 bit selector shared across the analog front-end blocks.
module mux4to1 (
  input  logic [3:0] a,
  input  logic [1:0] sel,
  output logic       o
);

  assign o = a[sel];

endmodule

// File: rtl/mux_scanner_ctrl.sv
// Scan sequencer: walks SEL over all channels, dwells, samples the mux
// output and publishes the whole word at once.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; outputs hold the last completed word
//   SETTLE | mux settling on channel SEL, dwell counter running down
//   SAMPLE | one cycle; O is captured into shadow[SEL] on the exit edge
//   FIN    | data holds the fresh word, done pulses, then back to IDLE
module mux_scanner_ctrl
  import mux_scanner_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              o,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] data,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0]   data_q, data_d;

  // State, channel pointer, dwell timer and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic; the last channel's bit is merged straight into data
  // so a partially built word never shows on the output.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          sel_d   = '0;
          cnt_d   = RELOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        shadow_d[sel_q] = o;
        if (sel_q == LAST_SEL) begin
          state_d = ST_FIN;
          data_d  = shadow_d;
        end else begin
          state_d = ST_SETTLE;
          sel_d   = sel_q + 1'b1;
          cnt_d   = RELOAD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  assign sel  = sel_q;
  assign data = data_q;
  assign busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done = (state_q == ST_FIN);

endmodule

// File: rtl/mux_scanner.sv
// Multiplexed channel scanner: shared 4:1 mux plus the scan sequencer.
// A is deliberately not registered; O follows A[SEL] combinationally.
module mux_scanner
  import mux_scanner_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scanner_if.slave  bus
);

  logic [SEL_W-1:0]  sel;
  logic              o;
  logic [NUM_CH-1:0] data;
  logic              busy;
  logic              done;

  generate
    if (DWELL < 1 || DWELL > DWELL_MAX) begin : g_bad_dwell
      $error("mux_scanner: DWELL=%0d outside 1..%0d", DWELL, DWELL_MAX);
    end
  endgenerate

  mux4to1 u_mux (
    .a   (bus.a),
    .sel (sel),
    .o   (o)
  );

  mux_scanner_ctrl #(
    .DWELL (DWELL)
  ) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.start),
    .o     (o),
    .sel   (sel),
    .data  (data),
    .busy  (busy),
    .done  (done)
  );

  assign bus.sel  = sel;
  assign bus.o    = o;
  assign bus.data = data;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule
